// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator with valid/ready handshakes and an optional skid entry.
// Define IMM_CSR_EN to decode format 5 (CSR zimm); otherwise it is reported as illegal.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic             o_valid_q, o_valid_d;
  logic [XLEN-1:0]  o_imm_q, o_imm_d;
  logic [TAG_W-1:0] o_tag_q, o_tag_d;
  logic             o_ill_q, o_ill_d;

  logic             k_valid_q, k_valid_d;
  logic [XLEN-1:0]  k_imm_q, k_imm_d;
  logic [TAG_W-1:0] k_tag_q, k_tag_d;
  logic             k_ill_q, k_ill_d;

  logic [31:0]      imm32;
  logic             new_ill;
  logic [XLEN-1:0]  new_imm;
  logic             accept;
  logic             o_free;

  // in_instr[n] holds instruction bit n+7
  always_comb begin
    imm32   = 32'd0;
    new_ill = 1'b0;
    case (in_imm_src)
      3'd0: imm32 = {{20{in_instr[24]}}, in_instr[24:13]};
      3'd1: imm32 = {{20{in_instr[24]}}, in_instr[24:18], in_instr[4:0]};
      3'd2: imm32 = {{20{in_instr[24]}}, in_instr[0], in_instr[23:18], in_instr[4:1], 1'b0};
      3'd3: imm32 = {{12{in_instr[24]}}, in_instr[12:5], in_instr[13], in_instr[23:14], 1'b0};
      3'd4: imm32 = {in_instr[24:5], 12'd0};
`ifdef IMM_CSR_EN
      3'd5: imm32 = {27'd0, in_instr[12:8]};
`else
      3'd5: new_ill = 1'b1;
`endif
      default: new_ill = 1'b1;
    endcase
  end

  // Every format is already sign-correct at bit 31, so widen from there
  always_comb begin
    new_imm       = {XLEN{imm32[31]}};
    new_imm[31:0] = imm32;
  end

  assign in_ready = (SKID != 0) ? !k_valid_q : (!o_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign o_free   = !o_valid_q || out_ready;

  always_comb begin
    o_valid_d = o_valid_q;
    o_imm_d   = o_imm_q;
    o_tag_d   = o_tag_q;
    o_ill_d   = o_ill_q;
    k_valid_d = k_valid_q;
    k_imm_d   = k_imm_q;
    k_tag_d   = k_tag_q;
    k_ill_d   = k_ill_q;
    if (flush) begin
      o_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (o_free) begin
      // An occupied skid entry blocks in_ready, so it never races a new accept
      if (k_valid_q) begin
        o_valid_d = 1'b1;
        o_imm_d   = k_imm_q;
        o_tag_d   = k_tag_q;
        o_ill_d   = k_ill_q;
        k_valid_d = 1'b0;
      end else if (accept) begin
        o_valid_d = 1'b1;
        o_imm_d   = new_imm;
        o_tag_d   = in_tag;
        o_ill_d   = new_ill;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      k_valid_d = 1'b1;
      k_imm_d   = new_imm;
      k_tag_d   = in_tag;
      k_ill_d   = new_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_imm_q   <= '0;
      o_tag_q   <= '0;
      o_ill_q   <= 1'b0;
      k_valid_q <= 1'b0;
      k_imm_q   <= '0;
      k_tag_q   <= '0;
      k_ill_q   <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_imm_q   <= o_imm_d;
      o_tag_q   <= o_tag_d;
      o_ill_q   <= o_ill_d;
      k_valid_q <= k_valid_d;
      k_imm_q   <= k_imm_d;
      k_tag_q   <= k_tag_d;
      k_ill_q   <= k_ill_d;
    end
  end

  assign out_valid   = o_valid_q;
  assign out_imm     = o_imm_q;
  assign out_tag     = o_tag_q;
  assign out_illegal = o_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit skid instance and a 64-bit no-skid instance share inputs.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [24:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [4:0]  a_out_tag;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [4:0]  b_out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
    .out_tag(a_out_tag), .out_illegal(a_out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
    .out_tag(b_out_tag), .out_illegal(b_out_illegal)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] src, input logic [4:0] tag);
    in_valid   = v;
    in_instr   = instr[31:7];
    in_imm_src = src;
    in_tag     = tag;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    #12;
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("rst_out_imm", {32'd0, a_out_imm}, 64'd0);
    chk("rst_out_tag", {59'd0, a_out_tag}, 64'd0);
    rst = 1'b0;
    step();

    // addi x1,x0,-1
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd3);
    step();
    chk("I_valid", {63'd0, a_out_valid}, 64'd1);
    chk("I_imm32", {32'd0, a_out_imm}, 64'hFFFF_FFFF);
    chk("I_tag", {59'd0, a_out_tag}, 64'd3);
    chk("I_ill", {63'd0, a_out_illegal}, 64'd0);
    chk("I_imm64", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    drive(1'b1, 32'hFE000EE3, 3'd2, 5'd4);
    step();
    chk("B_imm32", {32'd0, a_out_imm}, 64'hFFFF_FFFC);
    chk("B_tag", {59'd0, a_out_tag}, 64'd4);

    drive(1'b1, 32'hFE112E23, 3'd1, 5'd5);
    step();
    chk("S_imm32", {32'd0, a_out_imm}, 64'hFFFF_FFFC);

    drive(1'b1, 32'h0080006F, 3'd3, 5'd6);
    step();
    chk("J_imm64", b_out_imm, 64'd8);

    drive(1'b1, 32'h80000037, 3'd4, 5'd7);
    step();
    chk("U_imm32", {32'd0, a_out_imm}, 64'h8000_0000);
    chk("U_imm64", b_out_imm, 64'hFFFF_FFFF_8000_0000);

    drive(1'b1, 32'hFFFFFFFF, 3'd6, 5'd8);
    step();
    chk("undef_imm", {32'd0, a_out_imm}, 64'd0);
    chk("undef_ill", {63'd0, a_out_illegal}, 64'd1);

    drive(1'b1, 32'h000F8073, 3'd5, 5'd9);
    step();
`ifdef IMM_CSR_EN
    chk("Z_imm", {32'd0, a_out_imm}, 64'h1F);
    chk("Z_ill", {63'd0, a_out_illegal}, 64'd0);
`else
    chk("Z_imm", {32'd0, a_out_imm}, 64'd0);
    chk("Z_ill", {63'd0, a_out_illegal}, 64'd1);
`endif
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    step();
    chk("idle_valid", {63'd0, a_out_valid}, 64'd0);

    // Backpressure stream: tags 0..3
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 5'd0);
    step();
    chk("bp_b_in_ready", {63'd0, b_in_ready}, 64'd0);
    chk("bp_a_in_ready0", {63'd0, a_in_ready}, 64'd1);
    drive(1'b1, 32'h00200093, 3'd0, 5'd1);
    step();
    chk("bp_in_ready_drop", {63'd0, a_in_ready}, 64'd0);
    chk("bp_tag_hold0", {59'd0, a_out_tag}, 64'd0);
    drive(1'b1, 32'h00300093, 3'd0, 5'd2);
    step();
    chk("bp_tag_hold1", {59'd0, a_out_tag}, 64'd0);
    chk("bp_imm_hold", {32'd0, a_out_imm}, 64'd1);
    chk("bp_b_tag_hold", {59'd0, b_out_tag}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_out1", {59'd0, a_out_tag}, 64'd1);
    chk("bp_out1_valid", {63'd0, a_out_valid}, 64'd1);
    step();
    chk("bp_out2", {59'd0, a_out_tag}, 64'd2);
    chk("bp_out2_imm", {32'd0, a_out_imm}, 64'd3);
    drive(1'b1, 32'h00400093, 3'd0, 5'd3);
    step();
    chk("bp_out3", {59'd0, a_out_tag}, 64'd3);
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    step();
    chk("bp_drained", {63'd0, a_out_valid}, 64'd0);

    // Fill O and K, then flush with a live input handshake
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 5'd8);
    step();
    drive(1'b1, 32'h00100093, 3'd0, 5'd9);
    step();
    chk("fl_full", {63'd0, a_in_ready}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00100093, 3'd0, 5'd10);
    step();
    flush = 1'b0;
    chk("fl_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("fl_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("fl_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", {63'd0, a_out_valid}, 64'd0);
    drive(1'b1, 32'h00100093, 3'd0, 5'd11);
    step();
    chk("fl_next_tag", {59'd0, a_out_tag}, 64'd11);

    // Async reset between edges while both entries are full
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd12);
    step();
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("ar_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("ar_out_imm", {32'd0, a_out_imm}, 64'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 3'd0, 5'd13);
    step();
    chk("ar_first_valid", {63'd0, a_out_valid}, 64'd1);
    chk("ar_first_tag", {59'd0, a_out_tag}, 64'd13);
    chk("ar_first_imm", {32'd0, a_out_imm}, 64'd5);
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
